// File: rtl/ddr3_hammer_ctrl.sv
// Test-traffic sequencer for the DDR3 Avalon-MM port m0: strided write/read passes,
// perf-counter control, and read-back checking against an address-derived pattern.
module ddr3_hammer_ctrl #(
  parameter int unsigned ADDR_W          = 26,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter logic [63:0] SEED            = 64'hA5A5_5A5A_0F0F_F0F0
) (
  input  logic              ddr3_clk,
  input  logic              ddr3_reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] addr_stride,
  input  logic [31:0]       num_words,
  output logic              busy,
  output logic              done,
  output logic [31:0]       mismatch_cnt,
  output logic              clr_test_wcnt,
  output logic              clr_test_rcnt,
  output logic              cycle_cnt_en,
  output logic [ADDR_W-1:0] m0_address,
  output logic              m0_write,
  output logic [DATA_W-1:0] m0_writedata,
  output logic              m0_read,
  input  logic              m0_waitrequest,
  input  logic              m0_readdatavalid,
  input  logic [DATA_W-1:0] m0_readdata
);

  localparam int unsigned      OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_e;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ DATA_W'(SEED);
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [31:0]       num_q, num_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [31:0]       idx_q, idx_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [31:0]       mm_q, mm_d;
  logic              done_q, done_d;
  logic              wr_acc, rd_acc, ret_ok, last_idx;

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    base_d     = base_q;
    stride_d   = stride_q;
    num_d      = num_q;
    cmd_addr_d = cmd_addr_q;
    chk_addr_d = chk_addr_q;
    idx_d      = idx_q;
    out_d      = out_q;
    mm_d       = mm_q;
    done_d     = done_q;

    clr_test_wcnt = (state_q == S_CLR);
    clr_test_rcnt = (state_q == S_CLR);
    cycle_cnt_en  = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    m0_write      = (state_q == S_WRITE);
    m0_read       = (state_q == S_READ) && (out_q < OUT_MAX);
    m0_address    = (m0_write || m0_read) ? cmd_addr_q : '0;
    m0_writedata  = m0_write ? pat(cmd_addr_q) : '0;

    wr_acc   = m0_write && !m0_waitrequest;
    rd_acc   = m0_read && !m0_waitrequest;
    ret_ok   = m0_readdatavalid && (out_q != '0);
    last_idx = (idx_q == num_q - 32'd1);

    if (rd_acc && !ret_ok)      out_d = out_q + 1'b1;
    else if (!rd_acc && ret_ok) out_d = out_q - 1'b1;

    // Returns arrive in order, so a separate address walks the expected pattern.
    if (ret_ok) begin
      chk_addr_d = chk_addr_q + stride_q;
      if ((m0_readdata != pat(chk_addr_q)) && (mm_q != '1)) mm_d = mm_q + 32'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words != 32'd0) begin
            mode_d   = mode;
            base_d   = base_addr;
            stride_d = addr_stride;
            num_d    = num_words;
            done_d   = 1'b0;
            state_d  = S_CLR;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_CLR: begin
        mm_d       = '0;
        done_d     = 1'b0;
        cmd_addr_d = base_q;
        chk_addr_d = base_q;
        idx_d      = '0;
        state_d    = (mode_q == 2'b01) ? S_READ : S_WRITE;
      end
      S_WRITE: begin
        if (wr_acc) begin
          cmd_addr_d = cmd_addr_q + stride_q;
          idx_d      = idx_q + 32'd1;
          if (last_idx) begin
            if (mode_q[1]) begin
              cmd_addr_d = base_q;
              idx_d      = '0;
              state_d    = S_READ;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_READ: begin
        if (rd_acc) begin
          cmd_addr_d = cmd_addr_q + stride_q;
          idx_d      = idx_q + 32'd1;
          if (last_idx) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Looking at the next count saves a cycle between the last return and DONE.
        if (out_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge ddr3_clk) begin
    if (ddr3_reset) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      num_q      <= '0;
      cmd_addr_q <= '0;
      chk_addr_q <= '0;
      idx_q      <= '0;
      out_q      <= '0;
      mm_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      num_q      <= num_d;
      cmd_addr_q <= cmd_addr_d;
      chk_addr_q <= chk_addr_d;
      idx_q      <= idx_d;
      out_q      <= out_d;
      mm_q       <= mm_d;
      done_q     <= done_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_ddr3_hammer_ctrl.sv
// Self-checking bench for ddr3_hammer_ctrl: Avalon slave/memory model with stalls and
// read latency, plus a transaction-level reference of the expected traffic and compare count.
module tb_ddr3_hammer_ctrl;
  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 16;
  localparam logic [63:0] SEED = 64'hA5A5_5A5A_0F0F_F0F0;

  logic              ddr3_clk, ddr3_reset, start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr, addr_stride;
  logic [31:0]       num_words;
  logic              busy, done, clr_test_wcnt, clr_test_rcnt, cycle_cnt_en;
  logic [31:0]       mismatch_cnt;
  logic [ADDR_W-1:0] m0_address;
  logic              m0_write, m0_read, m0_waitrequest, m0_readdatavalid;
  logic [DATA_W-1:0] m0_writedata, m0_readdata;

  ddr3_hammer_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT), .SEED(SEED)
  ) dut (
    .ddr3_clk(ddr3_clk), .ddr3_reset(ddr3_reset), .start(start), .mode(mode),
    .base_addr(base_addr), .addr_stride(addr_stride), .num_words(num_words),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
    .clr_test_wcnt(clr_test_wcnt), .clr_test_rcnt(clr_test_rcnt), .cycle_cnt_en(cycle_cnt_en),
    .m0_address(m0_address), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
    .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata)
  );

  initial ddr3_clk = 1'b0;
  always #5 ddr3_clk = ~ddr3_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: i-th word address of a pass, modulo 2^ADDR_W, and its data pattern.
  function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] b, s, input int i);
    longint unsigned t;
    t = longint'(b) + longint'(i) * longint'(s);
    return t[ADDR_W-1:0];
  endfunction

  function automatic logic [63:0] pat_ref(input logic [ADDR_W-1:0] a);
    logic [63:0] z;
    z = 64'(a);
    return z ^ SEED;
  endfunction

  typedef struct { logic [ADDR_W-1:0] addr; int due; } pend_t;
  pend_t             pend[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  int cyc = 0;
  int wi = 0, ri = 0, ret_i = 0, exp_writes = 0, exp_reads = 0, exp_mm = 0;
  int out_model = 0, max_out = 0, clr_w = 0, clr_r = 0, en_cnt = 0, cmd_seen = 0;
  int first_cmd_cyc = -1, first_wr_cyc = -1, last_wr_cyc = -1, last_act = -1;
  int start_cyc = 0, done_cyc = 0;
  int stall_fixed = 0, stall_pct = 0, stall_cnt = 0, lat = 3, hold_until = 0;
  int corrupt_idx = -1, send_i = 0;
  bit corrupt_all = 1'b0;
  logic [ADDR_W-1:0] exp_base = '0, exp_stride = '0, last_wr_addr = '0;

  // Monitor (negedge) and slave responder (just after posedge) in one process.
  initial begin
    bit prev_stall_w, prev_stall_r;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data, d;
    logic [ADDR_W-1:0] ea;
    pend_t p;
    int pre;
    prev_stall_w = 1'b0; prev_stall_r = 1'b0; prev_addr = '0; prev_data = '0;
    m0_waitrequest = 1'b0; m0_readdatavalid = 1'b0; m0_readdata = '0;
    forever begin
      @(negedge ddr3_clk);
      if (m0_write || m0_read) begin
        cmd_seen++;
        check("rw_exclusive", 64'(m0_write & m0_read), 64'd0);
        if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
      end
      if (clr_test_wcnt) clr_w++;
      if (clr_test_rcnt) clr_r++;
      if (cycle_cnt_en) en_cnt++;
      if (!ddr3_reset) begin
        if (prev_stall_w) begin
          check("hold_w", 64'(m0_write), 64'd1);
          check("hold_w_addr", 64'(m0_address), 64'(prev_addr));
          check("hold_w_data", m0_writedata, prev_data);
        end
        if (prev_stall_r) begin
          check("hold_r", 64'(m0_read), 64'd1);
          check("hold_r_addr", 64'(m0_address), 64'(prev_addr));
        end
        pre = out_model;
        if (m0_readdatavalid && out_model > 0) begin
          ea = addr_at(exp_base, exp_stride, ret_i);
          if (m0_readdata !== pat_ref(ea)) exp_mm++;
          ret_i++;
          out_model--;
          last_act = cyc;
        end
        if (m0_write && !m0_waitrequest) begin
          ea = addr_at(exp_base, exp_stride, wi);
          check("wr_count", 64'(wi < exp_writes), 64'd1);
          check("wr_addr", 64'(m0_address), 64'(ea));
          check("wr_data", m0_writedata, pat_ref(ea));
          mem[m0_address] = m0_writedata;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc; last_wr_addr = m0_address;
          wi++; last_act = cyc; stall_cnt = 0;
        end
        if (m0_read && !m0_waitrequest) begin
          check("rd_order", 64'(wi), 64'(exp_writes));
          check("rd_count", 64'(ri < exp_reads), 64'd1);
          check("rd_addr", 64'(m0_address), 64'(addr_at(exp_base, exp_stride, ri)));
          check("rd_window", 64'(pre < MAX_OUT), 64'd1);
          pend.push_back('{addr: m0_address, due: cyc + lat});
          out_model++;
          if (out_model > max_out) max_out = out_model;
          ri++; stall_cnt = 0;
        end
        prev_stall_w = m0_write && m0_waitrequest;
        prev_stall_r = m0_read && m0_waitrequest;
        prev_addr = m0_address; prev_data = m0_writedata;
      end else begin
        out_model = 0; prev_stall_w = 1'b0; prev_stall_r = 1'b0; stall_cnt = 0;
      end

      @(posedge ddr3_clk); #1;
      cyc++;
      if ((m0_write || m0_read) && stall_cnt < stall_fixed) begin
        m0_waitrequest = 1'b1; stall_cnt++;
      end else if ((m0_write || m0_read) && int'($urandom_range(99)) < stall_pct) begin
        m0_waitrequest = 1'b1;
      end else begin
        m0_waitrequest = 1'b0;
      end
      if (pend.size() > 0 && cyc >= hold_until && pend[0].due <= cyc) begin
        p = pend.pop_front();
        d = mem.exists(p.addr) ? mem[p.addr] : {$urandom, $urandom};
        if (corrupt_all || send_i == corrupt_idx) d = d ^ 64'h1;
        send_i++;
        m0_readdatavalid = 1'b1; m0_readdata = d;
      end else begin
        m0_readdatavalid = 1'b0; m0_readdata = {$urandom, $urandom};
      end
    end
  end

  task automatic start_run(input logic [1:0] md, input logic [ADDR_W-1:0] b, s,
                           input logic [31:0] n);
    @(posedge ddr3_clk); #1;
    exp_base = b; exp_stride = s; wi = 0; ri = 0; ret_i = 0; exp_mm = 0;
    exp_writes = (n == 0 || md == 2'b01) ? 0 : int'(n);
    exp_reads  = (n == 0 || md == 2'b00) ? 0 : int'(n);
    clr_w = 0; clr_r = 0; en_cnt = 0; cmd_seen = 0; max_out = 0; send_i = 0;
    first_cmd_cyc = -1; first_wr_cyc = -1; last_act = -1;
    start = 1'b1; mode = md; base_addr = b; addr_stride = s; num_words = n;
    @(negedge ddr3_clk); start_cyc = cyc;
    @(posedge ddr3_clk); #1; start = 1'b0;
    @(negedge ddr3_clk);
    check("busy_at_clr", 64'(busy), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge ddr3_clk); k++;
    end
    check("done_seen", 64'(done), 64'd1);
    done_cyc = cyc;
  endtask

  task automatic finish_run();
    check("wr_total", 64'(wi), 64'(exp_writes));
    check("rd_total", 64'(ri), 64'(exp_reads));
    check("ret_total", 64'(ret_i), 64'(exp_reads));
    check("mismatch", 64'(mismatch_cnt), 64'(exp_mm));
    check("clr_w_pulses", 64'(clr_w), 64'd1);
    check("clr_r_pulses", 64'(clr_r), 64'd1);
    check("start_lat", 64'(first_cmd_cyc - start_cyc), 64'd2);
    check("done_lat", 64'(done_cyc - last_act), 64'd2);
    check("busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [1:0] md;
    logic [ADDR_W-1:0] b, s;
    logic [31:0] n;
    ddr3_reset = 1'b1; start = 1'b0; mode = '0; base_addr = '0; addr_stride = '0; num_words = '0;
    repeat (3) @(posedge ddr3_clk);
    @(negedge ddr3_clk);
    check("reset_outs", 64'({busy, done, clr_test_wcnt, clr_test_rcnt, cycle_cnt_en, m0_write, m0_read}), 64'd0);
    check("reset_mm", 64'(mismatch_cnt), 64'd0);
    @(posedge ddr3_clk); #1; ddr3_reset = 1'b0;

    // 1: write-only, no stalls
    start_run(2'b00, 26'h100, 26'd1, 32'd4);
    wait_done(100);
    finish_run();
    check("t1_en_cycles", 64'(en_cnt), 64'd4);
    check("t1_back_to_back", 64'(last_wr_cyc - first_wr_cyc), 64'd3);

    // 2: write-then-read, 2-cycle stalls, 5-cycle latency
    stall_fixed = 2; lat = 5;
    start_run(2'b10, 26'h400, 26'd8, 32'd3);
    wait_done(300);
    finish_run();
    stall_fixed = 0;

    // 3: read-only, returns withheld -> outstanding window fills
    lat = 2; hold_until = cyc + 35;
    start_run(2'b01, 26'h1000, 26'd1, 32'd40);
    wait_done(400);
    finish_run();
    check("t3_max_outstanding", 64'(max_out), 64'd16);

    // 4: corrupted 2nd return, then a clean rerun
    lat = 3; stall_pct = 20; corrupt_idx = 1;
    start_run(2'b10, 26'h3000, 26'd2, 32'd5);
    wait_done(400);
    finish_run();
    corrupt_idx = -1;
    start_run(2'b10, 26'h3000, 26'd2, 32'd5);
    wait_done(400);
    finish_run();
    stall_pct = 0;

    // 5a: address wrap
    start_run(2'b00, 26'h3FF_FFFE, 26'd1, 32'd4);
    wait_done(100);
    finish_run();
    check("wrap_last_addr", 64'(last_wr_addr), 64'd1);

    // 6: reset mid-READ with 5 reads outstanding, late returns ignored
    hold_until = cyc + 1000; lat = 1;
    start_run(2'b01, 26'h50, 26'd1, 32'd20);
    k = 0;
    while (out_model < 5 && k < 50) begin
      @(posedge ddr3_clk); #1; k++;
    end
    check("t6_outstanding", 64'(out_model), 64'd5);
    ddr3_reset = 1'b1;
    @(posedge ddr3_clk); #1; ddr3_reset = 1'b0;
    @(negedge ddr3_clk);
    check("midrst_outs", 64'({busy, done, clr_test_wcnt, clr_test_rcnt, cycle_cnt_en, m0_write, m0_read}), 64'd0);
    check("midrst_addr", 64'(m0_address), 64'd0);
    check("midrst_wdata", m0_writedata, 64'd0);
    check("midrst_mm", 64'(mismatch_cnt), 64'd0);
    corrupt_all = 1'b1; cmd_seen = 0; hold_until = cyc;
    repeat (30) @(negedge ddr3_clk);
    check("late_mm", 64'(mismatch_cnt), 64'd0);
    check("late_cmds", 64'(cmd_seen), 64'd0);
    check("late_returns_sent", 64'(pend.size()), 64'd0);
    corrupt_all = 1'b0;

    // 5b: num_words == 0
    @(posedge ddr3_clk); #1;
    clr_w = 0; cmd_seen = 0; exp_writes = 0; exp_reads = 0;
    start = 1'b1; mode = 2'b10; num_words = 32'd0;
    @(negedge ddr3_clk);
    check("zero_done_before", 64'(done), 64'd0);
    @(posedge ddr3_clk); #1; start = 1'b0;
    @(negedge ddr3_clk);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge ddr3_clk);
    check("zero_no_clr", 64'(clr_w), 64'd0);
    check("zero_no_cmds", 64'(cmd_seen), 64'd0);

    // 5c: start while busy is ignored (and inputs change mid-run)
    stall_pct = 30; lat = 2;
    start_run(2'b00, 26'h2000, 26'd3, 32'd8);
    repeat (3) @(posedge ddr3_clk);
    #1; start = 1'b1; mode = 2'b01; base_addr = 26'h5; addr_stride = 26'd7; num_words = 32'd2;
    @(posedge ddr3_clk); #1; start = 1'b0;
    wait_done(300);
    finish_run();

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      md = 2'($urandom_range(3));
      b = ADDR_W'($urandom);
      s = ($urandom_range(1) == 1) ? ADDR_W'($urandom_range(1, 16)) : ADDR_W'($urandom);
      n = 32'($urandom_range(1, 24));
      stall_pct = int'($urandom_range(0, 50));
      lat = int'($urandom_range(1, 8));
      corrupt_idx = int'($urandom_range(0, 30));
      hold_until = 0;
      start_run(md, b, s, n);
      wait_done(2000);
      finish_run();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ddr3_hammer_ctrl.md
Name: ddr3_hammer_ctrl

Overview:
- Test-traffic sequencer for the DDR3 Avalon-MM master port m0.
- Runs one write pass, one read pass, or a write-then-read pass over a strided address range.
- Drives the clear and cycle-enable controls of the performance-counter block, and checks read-back data against the written pattern.
- Sits between the host CSR block, the m0 port, and the perf counters.

Parameters:
ADDR_W, 26, m0 word-address width
DATA_W, 64, m0 data width (must be >= ADDR_W)
MAX_OUTSTANDING, 16, max read requests accepted but not yet returned
SEED, 64'hA5A5_5A5A_0F0F_F0F0, XOR mask applied to the data pattern

Ports:
ddr3_clk  in  1  clock
ddr3_reset  in  1  synchronous active-high reset
start  in  1  one-cycle run request; ignored while busy
mode  in  2  00 write-only, 01 read-only, 10 write-then-read, 11 treated as 10
base_addr  in  ADDR_W  first word address
addr_stride  in  ADDR_W  address increment per word
num_words  in  32  words per pass
busy  out  1  run in progress
done  out  1  sticky; set at run end, cleared by the next accepted start
mismatch_cnt  out  32  read-back compare failures in the current run
clr_test_wcnt  out  1  perf write-counter clear pulse
clr_test_rcnt  out  1  perf read-counter clear pulse
cycle_cnt_en  out  1  perf cycle-counter enable
m0_address  out  ADDR_W  Avalon address
m0_write  out  1  Avalon write
m0_writedata  out  DATA_W  Avalon write data
m0_read  out  1  Avalon read
m0_waitrequest  in  1  Avalon stall
m0_readdatavalid  in  1  Avalon read return
m0_readdata  in  DATA_W  Avalon read data

Behaviour:
- Reset (sync, active-high): state IDLE; all outputs 0; all internal counters 0.
- Reset mid-run aborts the run immediately; no further m0 commands are issued and in-flight returns are discarded.
- Data pattern: pat(a) = zero-extended a XOR SEED[DATA_W-1:0].
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- States:
  IDLE: on start with num_words!=0, latch mode, base_addr, addr_stride and num_words; set busy=1; go to CLR.
  IDLE: on start with num_words==0, set done=1 the next cycle and stay in IDLE; no clear pulses are issued.
  CLR: exactly one cycle. clr_test_wcnt=clr_test_rcnt=1, mismatch_cnt<=0, done<=0, cmd_addr<=base. Next state WRITE for mode 00/10, READ for mode 01.
  WRITE: m0_write=1, m0_address=cmd_addr, m0_writedata=pat(cmd_addr).
  - Acceptance = m0_write & ~m0_waitrequest. On each acceptance, cmd_addr+=stride and idx++.
  - While m0_waitrequest=1, address and data are held stable.
  - After the last acceptance (idx==num_words-1): mode 10 resets cmd_addr and idx and goes to READ; otherwise go to DONE.
  READ: m0_read=1 only while outstanding<MAX_OUTSTANDING.
  - Acceptance = m0_read & ~m0_waitrequest; it increments cmd_addr and idx.
  - After the last acceptance, go to DRAIN.
  DRAIN: no commands issued; when outstanding==0, go to DONE.
  DONE: one cycle; busy<=0, done<=1; go to IDLE.
- m0_read and m0_write are never asserted in the same cycle.
- cycle_cnt_en=1 exactly in WRITE, READ and DRAIN; it is 0 in CLR and DONE.
- Outstanding counter (width clog2(MAX_OUTSTANDING+1)):
  - +1 on read acceptance, -1 on m0_readdatavalid; no change when both occur in the same cycle.
  - A readdatavalid with outstanding==0 is ignored: no underflow, no compare.
- Read check:
  - A separate return address chk_addr starts at base and advances by stride on each valid return.
  - If m0_readdata != pat(chk_addr), mismatch_cnt++; it saturates at 32'hFFFF_FFFF.
  - Data is compared only in read passes; mode 01 reads whatever memory holds.
- A new start while busy=1 is ignored.
- Parameters latched in CLR are unaffected by input changes mid-run.
- Latency: start to first command is 2 cycles (IDLE->CLR->WRITE/READ). Last acceptance or last return to done is 2 cycles.

Test Plan:
1. Mode 00, base=0x100, stride=1, num_words=4, waitrequest=0 -> one-cycle clr pulses; 4 consecutive writes to 0x100..0x103 with data pat(a); done=1 two cycles after the last write; cycle_cnt_en high exactly 4 cycles.
2. Mode 10, stride=8, num_words=3, waitrequest high for 2 cycles on every command, 5-cycle read latency -> commands held stable during stalls; writes then reads to base, base+8, base+16; mismatch_cnt=0; done only after the third return.
3. Read pass with MAX_OUTSTANDING=16, num_words=40, returns withheld for 30 cycles -> m0_read deasserts after 16 acceptances; resumes as returns arrive; outstanding never exceeds 16.
4. Mode 10 with the memory model corrupting the 2nd read word -> mismatch_cnt=1. Rerun -> cleared to 0 in CLR; done drops at the new start.
5. Edge cases:
  - base=2^ADDR_W-2, stride=1, num_words=4 -> addresses wrap to 0 and 1.
  - num_words=0 -> done=1 with no m0 activity and no clr pulse.
  - start asserted while busy -> ignored.
6. ddr3_reset asserted mid-READ with 5 reads outstanding -> next cycle all outputs 0 and state IDLE. Late readdatavalid pulses do not change mismatch_cnt.
